qtable_ram: RTL
===============

QTABLE_RAM -- requirements
Module: qtable_ram

Interface
REQ-001 SHALL have parameter STATES, default 16, number of states.
REQ-002 SHALL have parameter ACTIONS, default 4, number of actions.
REQ-003 SHALL have parameter DATA_WIDTH, default 16, signed two's-complement Q-value width.
REQ-004 SHALL derive SW = max(1,clog2(STATES)) and AW = max(1,clog2(ACTIONS)).
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 i_clear  input  1  pulse that requests a full table clear.
REQ-008 o_busy  output  1  high while a clear sweep runs.
REQ-009 i_we  input  1  write enable.
REQ-010 i_wr_st / i_wr_at  input  SW / AW  write state / action.
REQ-011 i_data  input  DATA_WIDTH  write data.
REQ-012 i_re  input  1  read enable.
REQ-013 i_st / i_at / i_next_st  input  SW / AW / SW  current state, current action, next state.
REQ-014 o_valid  output  1  o_q and o_next_q valid.
REQ-015 o_q  output  DATA_WIDTH  Q(i_st,i_at).
REQ-016 o_next_q  output  DATA_WIDTH*ACTIONS  Q(i_next_st,a); action a occupies bits [a*DATA_WIDTH +: DATA_WIDTH].
REQ-017 o_max_valid  output  1  o_max_q and o_max_at valid.
REQ-018 o_max_q / o_max_at  output  DATA_WIDTH / AW  max over a of Q(i_next_st,a), and its action index.

Function
REQ-019 SHALL store STATES*ACTIONS entries at address at*STATES + st, action-major.
REQ-020 SHALL use a two-state FSM:
- IDLE: serves reads and writes.
- CLEAR: writes 0 to one address per cycle, from 0 to STATES*ACTIONS-1, then returns to IDLE.
REQ-021 SHALL enter CLEAR on the first clock after rst_n deasserts, and from IDLE when i_clear=1.
REQ-022 o_busy SHALL equal 1 exactly while in CLEAR; a sweep lasts STATES*ACTIONS cycles.
REQ-023 While busy, SHALL ignore i_we, i_re and i_clear; no restart and no o_valid.
REQ-024 In IDLE with i_we=1, SHALL write i_data to the addressed entry at the clock edge.
REQ-025 With i_re=1 at edge N in IDLE, o_q, o_next_q and o_valid=1 SHALL be registered at edge N; o_valid SHALL be low at any edge without an accepted read.
REQ-026 Outputs SHALL hold their last values while o_valid=0.
REQ-027 o_max_q, o_max_at and o_max_valid SHALL register at edge N+1, reduced from the registered o_next_q; reads are fully pipelined, one per cycle.
REQ-028 Max comparison SHALL be signed; on ties the lowest action index wins.
REQ-029 Read and write to the same address in the same cycle SHALL return the new i_data (write-first), for both o_q and any o_next_q slice.
REQ-030 A state index >= STATES SHALL make the write a no-op and make its read slices return 0.
REQ-031 i_clear and i_we in the same IDLE cycle: the write SHALL be performed, then the sweep SHALL start and overwrite it.

Reset
REQ-032 rst_n=0 SHALL asynchronously force:
- o_valid=0, o_max_valid=0, o_q=0, o_next_q=0, o_max_q=0, o_max_at=0;
- FSM to CLEAR with sweep counter=0 and o_busy=1.
REQ-033 RAM contents are not reset directly; zeroing comes only from the sweep.
REQ-034 Reset asserted mid-sweep SHALL restart the sweep from address 0 after release.

Verification (defaults 16/4/16)
REQ-035 Release rst_n -> o_busy=1 for exactly 64 cycles; then read st=7, at=3, next_st=9 -> o_q=0, o_next_q=0, o_max_q=0, o_max_at=0.
REQ-036 Write Q(3,2)=0x0100, then read st=3, at=2, next_st=3:
- 1 cycle later: o_valid=1, o_q=0x0100, o_next_q slice2=0x0100;
- 1 cycle after that: o_max_valid=1, o_max_q=0x0100, o_max_at=2.
REQ-037 Q(5,0..3) = {0xFFFB, 0x0007, 0x0007, 0xFFFF}, read next_st=5 -> o_max_q=0x0007, o_max_at=1 (signed, tie goes to the lower index).
REQ-038 Same-cycle write Q(4,1)=0x1234 and read st=4, at=1 -> o_q=0x1234.
REQ-039 Back-to-back reads on 3 consecutive cycles -> o_valid high 3 cycles and o_max_valid high 3 cycles, shifted by 1, with data matching per read.
REQ-040 i_clear, then i_re and i_we at sweep cycle 10 -> no o_valid, table all zero at end of sweep; rst_n pulse at sweep cycle 20 -> sweep restarts and o_busy lasts 64 cycles after release.

Source files
------------

// File: rtl/qtable_ram.sv
// Q-value table for a tabular RL agent.
// Layout: entry (st, at) lives at address at*STATES + st (action-major).
// After reset, or on an i_clear pulse, a sweep zeroes one address per cycle
// while o_busy is high. Requests presented during the sweep are dropped.
//
// Output handshake: there is no ready. A read is accepted on any edge where
// i_re=1 and o_busy=0. o_valid is high for exactly one cycle per accepted
// read, with o_q/o_next_q from that edge. o_max_valid follows one cycle later
// with the max of that o_next_q row. Every output holds its value while its
// valid is low.
module qtable_ram #(
  parameter int STATES     = 16,
  parameter int ACTIONS    = 4,
  parameter int DATA_WIDTH = 16,
  localparam int SW = (STATES  > 1) ? $clog2(STATES)  : 1,
  localparam int AW = (ACTIONS > 1) ? $clog2(ACTIONS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_clear,
  output logic                          o_busy,
  input  logic                          i_we,
  input  logic [SW-1:0]                 i_wr_st,
  input  logic [AW-1:0]                 i_wr_at,
  input  logic [DATA_WIDTH-1:0]         i_data,
  input  logic                          i_re,
  input  logic [SW-1:0]                 i_st,
  input  logic [AW-1:0]                 i_at,
  input  logic [SW-1:0]                 i_next_st,
  output logic                          o_valid,
  output logic [DATA_WIDTH-1:0]         o_q,
  output logic [DATA_WIDTH*ACTIONS-1:0] o_next_q,
  output logic                          o_max_valid,
  output logic [DATA_WIDTH-1:0]         o_max_q,
  output logic [AW-1:0]                 o_max_at,
  output logic                          o_dbg_state
);

  localparam int DEPTH = STATES * ACTIONS;
  localparam int CW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] LAST_ADDR = CW'(DEPTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e                        state_q, state_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic                          o_valid_q, o_valid_d;
  logic [DATA_WIDTH-1:0]         o_q_q, o_q_d;
  logic [DATA_WIDTH*ACTIONS-1:0] o_next_q_q, o_next_q_d;
  logic                          o_max_valid_q, o_max_valid_d;
  logic [DATA_WIDTH-1:0]         o_max_q_q, o_max_q_d;
  logic [AW-1:0]                 o_max_at_q, o_max_at_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  mem_we;
  logic [CW-1:0]         mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic wr_ok;
  logic rd_acc;

  function automatic logic [CW-1:0] addr_of(input logic [SW-1:0] st, input logic [AW-1:0] at);
    return CW'(32'(at) * STATES + 32'(st));
  endfunction

  function automatic logic st_ok(input logic [SW-1:0] st);
    return 32'(st) < STATES;
  endfunction

  function automatic logic at_ok(input logic [AW-1:0] at);
    return 32'(at) < ACTIONS;
  endfunction

  // Out-of-range state/action indices turn a write into a no-op.
  assign wr_ok  = (state_q == ST_IDLE) && i_we && st_ok(i_wr_st) && at_ok(i_wr_at);
  assign rd_acc = (state_q == ST_IDLE) && i_re;

  // FSM next state and the single RAM write port (sweep or user write).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = cnt_q;
    mem_wdata = '0;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        if (wr_ok) begin
          mem_we    = 1'b1;
          mem_waddr = addr_of(i_wr_st, i_wr_at);
          mem_wdata = i_data;
        end
        // A same-cycle write still lands; the sweep then overwrites it.
        if (i_clear) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // Read stage: write-first bypass, zero for invalid indices, hold when idle.
  always_comb begin
    o_valid_d  = rd_acc;
    o_q_d      = o_q_q;
    o_next_q_d = o_next_q_q;
    if (rd_acc) begin
      o_q_d = '0;
      if (st_ok(i_st) && at_ok(i_at)) begin
        if (wr_ok && (i_wr_st == i_st) && (i_wr_at == i_at)) begin
          o_q_d = i_data;
        end else begin
          o_q_d = mem_q[addr_of(i_st, i_at)];
        end
      end
      for (int a = 0; a < ACTIONS; a++) begin
        o_next_q_d[a*DATA_WIDTH +: DATA_WIDTH] = '0;
        if (st_ok(i_next_st)) begin
          if (wr_ok && (i_wr_st == i_next_st) && (i_wr_at == AW'(a))) begin
            o_next_q_d[a*DATA_WIDTH +: DATA_WIDTH] = i_data;
          end else begin
            o_next_q_d[a*DATA_WIDTH +: DATA_WIDTH] = mem_q[addr_of(i_next_st, AW'(a))];
          end
        end
      end
    end
  end

  // Max stage: signed reduction of the registered row; strict > keeps the lowest index on ties.
  always_comb begin
    o_max_valid_d = o_valid_q;
    o_max_q_d     = o_max_q_q;
    o_max_at_d    = o_max_at_q;
    if (o_valid_q) begin
      o_max_q_d  = o_next_q_q[DATA_WIDTH-1:0];
      o_max_at_d = '0;
      for (int a = 1; a < ACTIONS; a++) begin
        if ($signed(o_next_q_q[a*DATA_WIDTH +: DATA_WIDTH]) > $signed(o_max_q_d)) begin
          o_max_q_d  = o_next_q_q[a*DATA_WIDTH +: DATA_WIDTH];
          o_max_at_d = AW'(a);
        end
      end
    end
  end

  // Control and output registers; reset parks the FSM in CLEAR at address 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_CLEAR;
      cnt_q         <= '0;
      o_valid_q     <= 1'b0;
      o_q_q         <= '0;
      o_next_q_q    <= '0;
      o_max_valid_q <= 1'b0;
      o_max_q_q     <= '0;
      o_max_at_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      o_valid_q     <= o_valid_d;
      o_q_q         <= o_q_d;
      o_next_q_q    <= o_next_q_d;
      o_max_valid_q <= o_max_valid_d;
      o_max_q_q     <= o_max_q_d;
      o_max_at_q    <= o_max_at_d;
    end
  end

  // Table storage; contents are only ever zeroed by the sweep.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign o_busy      = (state_q == ST_CLEAR);
  assign o_dbg_state = state_q;
  assign o_valid     = o_valid_q;
  assign o_q         = o_q_q;
  assign o_next_q    = o_next_q_q;
  assign o_max_valid = o_max_valid_q;
  assign o_max_q     = o_max_q_q;
  assign o_max_at    = o_max_at_q;

endmodule
